// File: rtl/hdr_csum_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hdr_csum_pipe                                                |
// | Description : Pipelined, fully back-pressured IPv4-style header checksum   |
// |               insert unit. Each enabled beat has CSUM_DATA_WIDTH/16        |
// |               big-endian 16-bit words summed (one's complement) starting   |
// |               at byte csum_start, with the checksum field counted as zero. |
// |               The inverted result is written at byte csum_offset (MSB) and |
// |               csum_offset+1 (LSB). Disabled beats pass through unmodified  |
// |               with identical latency.                                      |
// |               Pipeline: capture, $clog2(NW) adder-tree levels, fold/insert.|
// | Ports       : clk, rst_n (async, active low)                               |
// |               csum_enable/csum_start/csum_offset  per-beat sideband        |
// |               stream_in_*   input stream  (data, valid, ready)             |
// |               stream_out_*  output stream (data, valid, ready)             |
// |               csum_verify, stream_out_err  only with HDR_CSUM_VERIFY_EN    |
// | Options     : HDR_CSUM_VERIFY_EN - adds per-beat verify mode; the field is |
// |               summed and stream_out_err flags a folded sum != 16'hFFFF.    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module hdr_csum_pipe #(
  parameter int AVST_DATA_WIDTH = 600,
  parameter int AVST_ADDR_WIDTH = 9,
  parameter int CSUM_DATA_WIDTH = 160
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       csum_enable,
  input  logic [AVST_ADDR_WIDTH-1:0] csum_start,
  input  logic [AVST_ADDR_WIDTH-1:0] csum_offset,
  input  logic [AVST_DATA_WIDTH-1:0] stream_in_data,
  input  logic                       stream_in_valid,
  output logic                       stream_in_ready,
  output logic [AVST_DATA_WIDTH-1:0] stream_out_data,
  output logic                       stream_out_valid,
  input  logic                       stream_out_ready
`ifdef HDR_CSUM_VERIFY_EN
  ,
  input  logic                       csum_verify,
  output logic                       stream_out_err
`endif
);

  localparam int c_NB     = AVST_DATA_WIDTH / 8;
  localparam int c_NW     = CSUM_DATA_WIDTH / 16;
  localparam int c_LEVELS = $clog2(c_NW);
  localparam int c_SW     = 16 + c_LEVELS;
  localparam int c_LAST   = c_LEVELS + 1;
  localparam int c_NS     = c_LEVELS + 2;

  // Bytes past the end of the beat read as zero.
  function automatic logic [7:0] byte_at(input logic [AVST_DATA_WIDTH-1:0] d, input int idx);
    logic [AVST_DATA_WIDTH-1:0] s;
    s = d >> (8 * idx);
    return (idx < c_NB) ? s[7:0] : 8'h00;
  endfunction

  logic                       w_in_vfy;
  logic [c_NS-1:0]            w_ld;
  logic [c_NS-1:0]            r_vld;
  logic [AVST_DATA_WIDTH-1:0] r_dat [c_LEVELS+1];
  logic [AVST_ADDR_WIDTH-1:0] r_off [c_LEVELS+1];
  logic [c_LEVELS:0]          r_en;
  logic [c_LEVELS:0]          r_vfy;
  logic [AVST_DATA_WIDTH-1:0] r_out_data;
  logic [15:0]                w_word [c_NW];

`ifdef HDR_CSUM_VERIFY_EN
  assign w_in_vfy = csum_verify;
`else
  assign w_in_vfy = 1'b0;
`endif

  // Stage k may load when it is empty or everything downstream of it can move.
  // Built from a running OR so each bit depends only on state and out_ready.
  always_comb begin
    logic w_acc;
    w_acc = stream_out_ready;
    w_ld  = '0;
    for (int k = c_NS - 1; k >= 0; k--) begin
      w_acc   = w_acc | ~r_vld[k];
      w_ld[k] = w_acc;
    end
  end

  assign stream_in_ready  = w_ld[0];
  assign stream_out_valid = r_vld[c_LAST];
  assign stream_out_data  = r_out_data;

  // Word j = {byte start+2j, byte start+2j+1}. The word that starts exactly on
  // the checksum field is zeroed; a misaligned field is therefore summed as-is.
  always_comb begin
    int w_idx;
    for (int j = 0; j < c_NW; j++) begin
      w_idx     = int'(csum_start) + 2 * j;
      w_word[j] = {byte_at(stream_in_data, w_idx), byte_at(stream_in_data, w_idx + 1)};
      if (!w_in_vfy && (w_idx == int'(csum_offset))) begin
        w_word[j] = 16'h0000;
      end
    end
  end

  // Adder tree: level 0 holds captured words, level l holds pair sums of
  // width 16+l so no carry is ever lost before the fold.
  for (genvar l = 0; l <= c_LEVELS; l++) begin : g_lvl
    localparam int c_CNT = (c_NW + (1 << l) - 1) >> l;
    logic [15+l:0] r_sum [c_CNT];

    if (l == 0) begin : g_cap
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < c_CNT; i++) r_sum[i] <= '0;
        end else if (w_ld[0] && stream_in_valid) begin
          for (int i = 0; i < c_CNT; i++) r_sum[i] <= w_word[i];
        end
      end
    end else begin : g_add
      localparam int c_PCNT = (c_NW + (1 << (l - 1)) - 1) >> (l - 1);
      logic [15+l:0] w_sum [c_CNT];

      for (genvar i = 0; i < c_CNT; i++) begin : g_node
        if (2 * i + 1 < c_PCNT) begin : g_pair
          assign w_sum[i] = {1'b0, g_lvl[l-1].r_sum[2*i]} + {1'b0, g_lvl[l-1].r_sum[2*i+1]};
        end else begin : g_pass
          assign w_sum[i] = {1'b0, g_lvl[l-1].r_sum[2*i]};
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < c_CNT; i++) r_sum[i] <= '0;
        end else if (w_ld[l] && r_vld[l-1]) begin
          for (int i = 0; i < c_CNT; i++) r_sum[i] <= w_sum[i];
        end
      end
    end
  end

  // Fold: two end-around-carry passes are enough for any sum up to 32 bits.
  logic [c_SW-1:0]            w_tot;
  logic [16:0]                w_f1;
  logic [15:0]                w_f2;
  logic [15:0]                w_csum;
  logic [AVST_DATA_WIDTH-1:0] w_ins;

  assign w_tot  = g_lvl[c_LEVELS].r_sum[0];
  assign w_f1   = {1'b0, w_tot[15:0]} + 17'(w_tot >> 16);
  assign w_f2   = w_f1[15:0] + {15'd0, w_f1[16]};
  assign w_csum = ~w_f2;

  // Byte-wise compare keeps writes at or past the end of the beat suppressed.
  always_comb begin
    w_ins = r_dat[c_LEVELS];
    if (r_en[c_LEVELS] && !r_vfy[c_LEVELS]) begin
      for (int b = 0; b < c_NB; b++) begin
        if (b == int'(r_off[c_LEVELS]))     w_ins[8*b +: 8] = w_csum[15:8];
        if (b == int'(r_off[c_LEVELS]) + 1) w_ins[8*b +: 8] = w_csum[7:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld      <= '0;
      r_en       <= '0;
      r_vfy      <= '0;
      r_out_data <= '0;
      for (int k = 0; k <= c_LEVELS; k++) begin
        r_dat[k] <= '0;
        r_off[k] <= '0;
      end
    end else begin
      if (w_ld[0]) begin
        r_vld[0] <= stream_in_valid;
        if (stream_in_valid) begin
          r_dat[0] <= stream_in_data;
          r_off[0] <= csum_offset;
          r_en[0]  <= csum_enable;
          r_vfy[0] <= w_in_vfy;
        end
      end
      for (int k = 1; k <= c_LEVELS; k++) begin
        if (w_ld[k]) begin
          r_vld[k] <= r_vld[k-1];
          if (r_vld[k-1]) begin
            r_dat[k] <= r_dat[k-1];
            r_off[k] <= r_off[k-1];
            r_en[k]  <= r_en[k-1];
            r_vfy[k] <= r_vfy[k-1];
          end
        end
      end
      if (w_ld[c_LAST]) begin
        r_vld[c_LAST] <= r_vld[c_LEVELS];
        if (r_vld[c_LEVELS]) r_out_data <= w_ins;
      end
    end
  end

`ifdef HDR_CSUM_VERIFY_EN
  logic r_out_err;
  assign stream_out_err = r_out_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_err <= 1'b0;
    end else if (w_ld[c_LAST] && r_vld[c_LEVELS]) begin
      r_out_err <= r_en[c_LEVELS] && r_vfy[c_LEVELS] && (w_f2 != 16'hFFFF);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_hdr_csum_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_hdr_csum_pipe                                             |
// | Description : Scoreboard bench for hdr_csum_pipe. Expected beats are       |
// |               queued on accept and compared when the output handshakes.    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_hdr_csum_pipe;
  localparam int DW  = 600;
  localparam int AW  = 9;
  localparam int NB  = DW / 8;
  localparam int NW  = 10;
  localparam int LAT = 6;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          e;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          csum_enable = 1'b0;
  logic [AW-1:0] csum_start = '0;
  logic [AW-1:0] csum_offset = '0;
  logic [DW-1:0] stream_in_data = '0;
  logic          stream_in_valid = 1'b0;
  logic          stream_in_ready;
  logic [DW-1:0] stream_out_data;
  logic          stream_out_valid;
  logic          stream_out_ready = 1'b1;
`ifdef HDR_CSUM_VERIFY_EN
  logic          csum_verify = 1'b0;
  logic          stream_out_err;
`endif

  int   n_chk  = 0;
  int   n_fail = 0;
  int   ncyc   = 0;
  logic rand_rdy = 1'b0;
  exp_t exp_q[$];
  int   hs_log[$];
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  exp_t m_e;
  logic [7:0] c_hdr [20] = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
                             8'h00, 8'h00, 8'hc0, 8'ha8, 8'h00, 8'h01, 8'hc0, 8'ha8, 8'h00, 8'hc7};

  hdr_csum_pipe #(
    .AVST_DATA_WIDTH (DW),
    .AVST_ADDR_WIDTH (AW),
    .CSUM_DATA_WIDTH (160)
  ) u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .csum_enable      (csum_enable),
    .csum_start       (csum_start),
    .csum_offset      (csum_offset),
    .stream_in_data   (stream_in_data),
    .stream_in_valid  (stream_in_valid),
    .stream_in_ready  (stream_in_ready),
    .stream_out_data  (stream_out_data),
    .stream_out_valid (stream_out_valid),
    .stream_out_ready (stream_out_ready)
`ifdef HDR_CSUM_VERIFY_EN
    ,
    .csum_verify      (csum_verify),
    .stream_out_err   (stream_out_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gb(input logic [DW-1:0] d, input int idx);
    if (idx < NB) return d[8*idx +: 8];
    return 8'h00;
  endfunction

  function automatic logic [DW-1:0] model(input logic [DW-1:0] d, input logic en, input logic vfy,
                                          input int st, input int off, output logic err);
    logic [31:0]   s;
    logic [15:0]   w;
    logic [15:0]   r;
    logic [DW-1:0] o;
    s = 32'd0;
    for (int j = 0; j < NW; j++) begin
      w = {gb(d, st + 2*j), gb(d, st + 2*j + 1)};
      if (!vfy && (st + 2*j == off)) w = 16'h0000;
      s = s + 32'(w);
    end
    while (s[31:16] != 16'h0000) s = 32'(s[15:0]) + 32'(s[31:16]);
    r   = ~s[15:0];
    err = en && vfy && (s[15:0] != 16'hFFFF);
    o   = d;
    if (en && !vfy) begin
      if (off < NB)     o[8*off +: 8]     = r[15:8];
      if (off + 1 < NB) o[8*(off+1) +: 8] = r[7:0];
    end
    return o;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW; i++) d[i] = 1'($urandom_range(0, 1));
    return d;
  endfunction

  function automatic logic [DW-1:0] build_hdr();
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < 20; i++) d[8*i +: 8] = c_hdr[i];
    return d;
  endfunction

  // Present one beat and hold it until accepted; the expectation is queued
  // on the cycle the handshake happens.
  task automatic send(input logic [DW-1:0] d, input logic en, input int st, input int off,
                      input logic [DW-1:0] exp_d, input logic exp_e);
    int   n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    stream_in_data  = d;
    csum_enable     = en;
    csum_start      = AW'(st);
    csum_offset     = AW'(off);
    stream_in_valid = 1'b1;
    while (!acc) begin
      @(negedge clk);
      acc = stream_in_ready;
      if (acc) exp_q.push_back('{d: exp_d, e: exp_e});
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 1000) begin
        chk("in_ready_timeout", DW'(acc), DW'(1));
        acc = 1'b1;
      end
    end
    stream_in_valid = 1'b0;
  endtask

  task automatic send_model(input logic [DW-1:0] d, input logic en, input logic vfy,
                            input int st, input int off);
    logic [DW-1:0] e;
    logic          err;
    e = model(d, en, vfy, st, off, err);
    send(d, en, st, off, e, err);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk("drain", DW'(exp_q.size()), DW'(0));
    #1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      stream_out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: stability under stall plus in-order scoreboard compare.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", DW'(stream_out_valid), DW'(1));
        chk("stall_data", stream_out_data, prev_data);
      end
      if (stream_out_valid && stream_out_ready) begin
        hs_log.push_back(ncyc);
        chk("beat_expected", DW'(exp_q.size() > 0), DW'(1));
        if (exp_q.size() > 0) begin
          m_e = exp_q.pop_front();
          chk("data", stream_out_data, m_e.d);
`ifdef HDR_CSUM_VERIFY_EN
          chk("err", DW'(stream_out_err), DW'(m_e.e));
`endif
        end
      end
      prev_stall = stream_out_valid && !stream_out_ready;
      prev_data  = stream_out_data;
    end
    ncyc++;
  end

  initial begin
    logic [DW-1:0] hdr;
    logic [DW-1:0] hexp;
    logic [DW-1:0] d;
    logic          v;
    int            n0;
    int            lat;
    int            span;
    int            st;
    int            off;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", DW'(stream_out_valid), DW'(0));
    chk("rst_out_data", stream_out_data, DW'(0));
`ifdef HDR_CSUM_VERIFY_EN
    chk("rst_out_err", DW'(stream_out_err), DW'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", DW'(stream_in_ready), DW'(1));

    // T1: reference header, checksum b8 61 after LAT cycles
    hdr  = build_hdr();
    hexp = hdr;
    hexp[8*10 +: 8] = 8'hb8;
    hexp[8*11 +: 8] = 8'h61;
    send(hdr, 1'b1, 0, 10, hexp, 1'b0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!stream_out_valid && lat < 20);
    chk("latency", DW'(lat), DW'(LAT));
    drain();

    // T2: garbage in the field is excluded
    d = hdr;
    d[8*10 +: 8] = 8'hff;
    d[8*11 +: 8] = 8'hff;
    send(d, 1'b1, 0, 10, hexp, 1'b0);
    drain();

    // T3: 100 back-to-back beats, alternating enable
    n0 = hs_log.size();
    for (int i = 0; i < 100; i++) begin
      st  = $urandom_range(0, 50);
      off = st + 2 * $urandom_range(0, NW - 1);
      send_model(rand_data(), 1'((i % 2) == 0), 1'b0, st, off);
    end
    drain();
    chk("t3_count", DW'(hs_log.size() - n0), DW'(100));
    span = (hs_log.size() >= n0 + 100) ? hs_log[n0+99] - hs_log[n0] : -1;
    chk("t3_span", DW'(span), DW'(99));

    // T4: random back-pressure, random start/offset
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      st  = $urandom_range(0, 70);
      off = ($urandom_range(0, 1) == 1) ? st + 2 * $urandom_range(0, NW - 1)
                                        : $urandom_range(0, NB + 4);
      v   = 1'b0;
`ifdef HDR_CSUM_VERIFY_EN
      v           = 1'($urandom_range(0, 3) == 0);
      csum_verify = v;
`endif
      send_model(rand_data(), 1'($urandom_range(0, 3) != 0), v, st, off);
    end
`ifdef HDR_CSUM_VERIFY_EN
    csum_verify = 1'b0;
`endif
    drain();
    rand_rdy = 1'b0;
    @(posedge clk);
    #1;

    // T5: field at the last byte / past the end, then reset mid-stream
    send_model(rand_data(), 1'b1, 1'b0, 60, NB - 1);
    send_model(rand_data(), 1'b1, 1'b0, 70, NB);
    send_model(rand_data(), 1'b1, 1'b0, NB - 2, NB - 2);
    drain();
    for (int i = 0; i < 8; i++) send_model(rand_data(), 1'b1, 1'b0, 0, 2 * (i % NW));
    #3;
    chk("rst_pre_valid", DW'(stream_out_valid), DW'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", DW'(stream_out_valid), DW'(0));
    chk("rst_mid_data", stream_out_data, DW'(0));
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n0 = hs_log.size();
    repeat (12) @(posedge clk);
    #1;
    chk("no_stale_beat", DW'(hs_log.size() - n0), DW'(0));

`ifdef HDR_CSUM_VERIFY_EN
    // T6: verify mode on a correct and a corrupted header
    csum_verify = 1'b1;
    send(hexp, 1'b1, 0, 10, hexp, 1'b0);
    d = hexp;
    d[8*3 +: 8] = 8'h74;
    send(d, 1'b1, 0, 10, d, 1'b1);
    csum_verify = 1'b0;
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
